// File: rtl/sha1_pkg.sv
// Shared constants and types for the SHA-1 message sequencer.
package sha1_pkg;

  localparam int BLK_W = 512;
  localparam int CV_W  = 160;

  localparam logic [CV_W-1:0] SHA1_IV = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_OUT
  } seq_state_t;

endpackage

// File: rtl/sha1_msg_sequencer.sv
// SHA-1 message sequencer: takes padded 512-bit blocks, issues one core start
// per block, chains the chaining value across blocks of a message and holds
// the final digest until the consumer takes it.
// Optional cycle counter (cyc_count) enabled by defining SHA1_SEQ_PERF_CNT_EN.
module sha1_msg_sequencer
  import sha1_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int START_HOLD = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [BLK_W-1:0]  blk_data,
  input  logic              blk_last,
  output logic              core_start,
  output logic              core_use_prev_cv,
  output logic [BLK_W-1:0]  core_data,
  output logic [CV_W-1:0]   core_cv,
  input  logic              core_busy,
  input  logic              core_out_valid,
  input  logic [CV_W-1:0]   core_cv_next,
  output logic              digest_valid,
  input  logic              digest_ready,
  output logic [CV_W-1:0]   digest,
  output logic [CNT_W-1:0]  blk_count
`ifdef SHA1_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       cyc_count
`endif
);

  localparam logic [1:0] HOLD_LAST = 2'(START_HOLD - 1);

  seq_state_t  state;
  logic        first_flag;
  logic        last_flag;
  logic [1:0]  hold_cnt;
  logic        core_busy_p1;
  logic        blk_acc;
  logic        blk_done;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign core_cv = SHA1_IV;

  assign blk_acc = (state == ST_IDLE) && blk_valid && blk_ready;

  // A block completes on out_valid, or on busy falling if out_valid never came.
  assign blk_done = ((state == ST_WAIT_BUSY) && core_out_valid) ||
                    ((state == ST_WAIT_DONE) && (core_out_valid || (core_busy_p1 && !core_busy)));

  // Delayed copy of core_busy for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) core_busy_p1 <= 1'b0;
    else       core_busy_p1 <= core_busy;
  end

  // Main sequencing FSM with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= ST_IDLE;
      blk_ready        <= 1'b0;
      core_start       <= 1'b0;
      core_use_prev_cv <= 1'b0;
      core_data        <= '0;
      digest_valid     <= 1'b0;
      digest           <= '0;
      blk_count        <= '0;
      first_flag       <= 1'b1;
      last_flag        <= 1'b0;
      hold_cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (blk_acc) begin
            core_data        <= blk_data;
            last_flag        <= blk_last;
            core_use_prev_cv <= !first_flag;
            if (first_flag) blk_count <= '0;
            blk_ready        <= 1'b0;
            core_start       <= 1'b1;
            hold_cnt         <= '0;
            state            <= ST_ISSUE;
          end else begin
            blk_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (hold_cnt == HOLD_LAST) begin
            core_start <= 1'b0;
            state      <= ST_WAIT_BUSY;
          end else begin
            hold_cnt <= hold_cnt + 2'd1;
          end
        end
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          if (blk_done) begin
            blk_count <= sat_inc_cnt(blk_count);
            if (last_flag) begin
              digest       <= core_cv_next;
              digest_valid <= 1'b1;
              state        <= ST_OUT;
            end else begin
              first_flag <= 1'b0;
              blk_ready  <= 1'b1;
              state      <= ST_IDLE;
            end
          end else if ((state == ST_WAIT_BUSY) && core_busy) begin
            state <= ST_WAIT_DONE;
          end
        end
        ST_OUT: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            first_flag   <= 1'b1;
            blk_ready    <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SHA1_SEQ_PERF_CNT_EN
  logic cyc_run;

  function automatic logic [31:0] sat_inc_32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Cycles from first-block accept up to the edge that raises digest_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_count <= '0;
      cyc_run   <= 1'b0;
    end else if (blk_acc && first_flag) begin
      cyc_count <= '0;
      cyc_run   <= 1'b1;
    end else if (cyc_run) begin
      cyc_count <= sat_inc_32(cyc_count);
      if (blk_done && last_flag) cyc_run <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sha1_msg_sequencer.sv
// Scoreboard bench for sha1_msg_sequencer with a behavioural SHA-1 core model.
module tb_sha1_msg_sequencer;
  import sha1_pkg::*;

  localparam int CNT_W      = 16;
  localparam int START_HOLD = 1;

  logic              clk = 1'b0;
  logic              rstn;
  logic              blk_valid;
  logic              blk_ready;
  logic [511:0]      blk_data;
  logic              blk_last;
  logic              core_start;
  logic              core_use_prev_cv;
  logic [511:0]      core_data;
  logic [159:0]      core_cv;
  logic              core_busy;
  logic              core_out_valid;
  logic [159:0]      core_cv_next;
  logic              digest_valid;
  logic              digest_ready;
  logic [159:0]      digest;
  logic [CNT_W-1:0]  blk_count;
`ifdef SHA1_SEQ_PERF_CNT_EN
  logic [31:0]       cyc_count;
`endif

  sha1_msg_sequencer #(.CNT_W(CNT_W), .START_HOLD(START_HOLD)) dut (
    .clk(clk), .rstn(rstn),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .core_start(core_start), .core_use_prev_cv(core_use_prev_cv), .core_data(core_data),
    .core_cv(core_cv), .core_busy(core_busy), .core_out_valid(core_out_valid),
    .core_cv_next(core_cv_next),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest),
    .blk_count(blk_count)
`ifdef SHA1_SEQ_PERF_CNT_EN
    , .cyc_count(cyc_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [511:0] got, logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  // ---------------- SHA-1 reference arithmetic ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [159:0] sha1_compress(input logic [159:0] cv, input logic [511:0] blk);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 80; i++) w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
    a = cv[159:128]; b = cv[127:96]; c = cv[95:64]; d = cv[63:32]; e = cv[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = rol(a, 5) + f + e + k + w[i];
      e = d; d = c; c = rol(b, 30); b = a; a = t;
    end
    return {cv[159:128] + a, cv[127:96] + b, cv[95:64] + c, cv[63:32] + d, cv[31:0] + e};
  endfunction

  logic [511:0] msg_blk[4];

  function automatic logic [159:0] ref_digest(input int n);
    logic [159:0] cv = SHA1_IV;
    for (int b = 0; b < n; b++) cv = sha1_compress(cv, msg_blk[b]);
    return cv;
  endfunction

  // ---------------- scoreboard queues ----------------
  logic [512:0] blk_exp_q[$];   // {use_prev_cv, data}
  logic [159:0] dig_exp_q[$];
  int           cnt_exp_q[$];

  logic        drv_first = 1'b0;
  logic        hold_mode = 1'b0;
  int          held = 0;
  logic        force_mode = 1'b0;

  // ---------------- behavioural core ----------------
  int           cs, m_mode, m_len;
  logic         s_rst, s_start, s_prev, m_prev;
  logic [511:0] s_data, m_data;
  logic [159:0] m_cv, m_res;

  initial begin
    core_busy = 1'b0; core_out_valid = 1'b0; core_cv_next = '0; cs = 0; m_cv = SHA1_IV;
    forever begin
      @(negedge clk);
      s_rst = rstn; s_start = core_start; s_prev = core_use_prev_cv; s_data = core_data;
      @(posedge clk); #1;
      if (!s_rst || !rstn) begin
        cs = 0; core_busy = 1'b0; core_out_valid = 1'b0;
      end else begin
        case (cs)
          0: if (s_start) begin m_prev = s_prev; m_data = s_data; cs = 1; end
          1: if (!s_start) begin
               m_res = sha1_compress(m_prev ? m_cv : SHA1_IV, m_data);
               m_cv  = m_res;
               m_mode = force_mode ? 0 : int'($urandom_range(0, 2));
               m_len  = force_mode ? 8 : int'($urandom_range(1, 5));
               core_busy = 1'b1;
               core_cv_next = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
               if (m_mode == 2) begin core_out_valid = 1'b1; core_cv_next = m_res; cs = 3; end
               else cs = 2;
             end
          2: begin
               if (m_len > 1) m_len--;
               else if (m_mode == 0) begin core_out_valid = 1'b1; core_cv_next = m_res; cs = 3; end
               else begin core_busy = 1'b0; core_cv_next = m_res; cs = 0; end
             end
          default: begin core_busy = 1'b0; core_out_valid = 1'b0; cs = 0; end
        endcase
      end
    end
  end

  // ---------------- digest consumer ----------------
  initial begin
    digest_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_mode && digest_valid) begin
        if (held < 10) begin digest_ready = 1'b0; held++; end
        else begin digest_ready = 1'b1; hold_mode = 1'b0; end
      end else if (!hold_mode) begin
        digest_ready = $urandom_range(0, 1) == 1;
      end else begin
        digest_ready = $urandom_range(0, 1) == 1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic         start_q = 1'b0, dv_q = 1'b0, exp_drop = 1'b0;
  logic [159:0] dig_q;
  logic [512:0] e;
  int unsigned  t_acc = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        start_q = 1'b0; dv_q = 1'b0; exp_drop = 1'b0;
      end else begin
        if (blk_valid && blk_ready && drv_first) t_acc = cyc + 1;
        if (core_start) chk("start_while_busy", core_busy, 0);
        if (core_start && !start_q) begin
          if (blk_exp_q.size() == 0) chk("unexpected_start", core_start, 0);
          else begin
            e = blk_exp_q.pop_front();
            chk("use_prev_cv", core_use_prev_cv, e[512]);
            chk("core_data", core_data, e[511:0]);
            chk("core_cv", core_cv, SHA1_IV);
          end
        end
        if (exp_drop) begin chk("digest_valid_drop", digest_valid, 0); exp_drop = 1'b0; end
        if (digest_valid) begin
          chk("blk_ready_in_out", blk_ready, 0);
          if (dv_q) chk("digest_stable", digest, dig_q);
          else if (dig_exp_q.size() == 0) chk("unexpected_digest", digest_valid, 0);
          else begin
            chk("digest", digest, dig_exp_q.pop_front());
            chk("blk_count", blk_count, cnt_exp_q.pop_front());
`ifdef SHA1_SEQ_PERF_CNT_EN
            chk("cyc_count", cyc_count, cyc - t_acc);
`endif
          end
          dig_q = digest;
          if (digest_ready) exp_drop = 1'b1;
        end
        dv_q = digest_valid;
        start_q = core_start;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_accept();
    int t = 0;
    do begin @(negedge clk); t++; end while (!(blk_ready && blk_valid) && t < 2000);
    if (t >= 2000) chk("accept_timeout", blk_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_msg(input int n, input logic [159:0] exp_dig);
    dig_exp_q.push_back(exp_dig);
    cnt_exp_q.push_back(n);
    for (int b = 0; b < n; b++) begin
      blk_exp_q.push_back({b != 0, msg_blk[b]});
      drv_first = (b == 0);
      blk_data  = msg_blk[b];
      blk_last  = (b == n - 1);
      blk_valid = 1'b1;
      wait_accept();
      drv_first = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        blk_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((dig_exp_q.size() != 0 || blk_exp_q.size() != 0) && t < 5000) begin
      @(negedge clk); t++;
    end
    if (t >= 5000) chk("drain_timeout", dig_exp_q.size(), 0);
    blk_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [447:0] two_msg;
  int           n, t;

  initial begin
    rstn = 1'b0; blk_valid = 1'b0; blk_data = '0; blk_last = 1'b0;
    two_msg = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_blk_ready", blk_ready, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_use_prev", core_use_prev_cv, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_digest_valid", digest_valid, 0);
    chk("rst_digest", digest, 0);
    chk("rst_blk_count", blk_count, 0);
    chk("rst_core_cv", core_cv, SHA1_IV);
`ifdef SHA1_SEQ_PERF_CNT_EN
    chk("rst_cyc_count", cyc_count, 0);
`endif
    @(posedge clk); #3 rstn = 1'b1;
    @(posedge clk); #1;

    // single-block "abc"
    msg_blk[0] = {24'h616263, 8'h80, 416'd0, 64'd24};
    send_msg(1, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
    drain();

    // two-block message, digest held for 10 cycles before accept
    msg_blk[0] = {two_msg, 8'h80, 56'd0};
    msg_blk[1] = {448'd0, 64'd448};
    held = 0; hold_mode = 1'b1;
    send_msg(2, 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1);
    drain();

    // back-to-back random messages, blk_valid mostly kept high
    for (int m = 0; m < 12; m++) begin
      n = $urandom_range(1, 3);
      for (int b = 0; b < n; b++)
        for (int w = 0; w < 16; w++) msg_blk[b][w*32 +: 32] = $urandom();
      send_msg(n, ref_digest(n));
    end
    drain();

    // reset while block 1 of 2 is inside the core
    force_mode = 1'b1;
    msg_blk[0] = {two_msg, 8'h80, 56'd0};
    blk_exp_q.push_back({1'b0, msg_blk[0]});
    drv_first = 1'b1; blk_data = msg_blk[0]; blk_last = 1'b0; blk_valid = 1'b1;
    wait_accept();
    drv_first = 1'b0; blk_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!core_busy && t < 200);
    if (t >= 200) chk("busy_timeout", core_busy, 1);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_blk_ready", blk_ready, 0);
    chk("mid_rst_core_start", core_start, 0);
    chk("mid_rst_core_data", core_data, 0);
    chk("mid_rst_digest_valid", digest_valid, 0);
    chk("mid_rst_blk_count", blk_count, 0);
    blk_exp_q.delete(); dig_exp_q.delete(); cnt_exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    force_mode = 1'b0;
    @(posedge clk); #1;
    msg_blk[0] = {24'h616263, 8'h80, 416'd0, 64'd24};
    send_msg(1, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sha1_msg_sequencer.md
Name: sha1_msg_sequencer

Overview:
- Streaming front-end controller for the SHA-1 compression core (`top`).
- Accepts pre-padded 512-bit message blocks over a valid/ready handshake and issues one core `start` per block.
- Drives `use_prev_cv` for chaining: the first block uses the standard IV, later blocks chain the previous `cv_next`.
- Captures and holds the final 160-bit digest until the consumer accepts it. Sits between the AXI/register shim and the core.

Parameters:
- CNT_W, 16, width of the per-message block counter (saturating).
- START_HOLD, 1, cycles `core_start` is held high per block (1..4).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- blk_valid  in  1  input block valid
- blk_ready  out  1  sequencer can accept a block
- blk_data  in  512  padded message block, word 0 in [511:480]
- blk_last  in  1  block is final block of message
- core_start  out  1  to core `start`
- core_use_prev_cv  out  1  to core `use_prev_cv`
- core_data  out  512  to core `data_i` (registered)
- core_cv  out  160  to core `cv`; constant SHA1_IV
- core_busy  in  1  from core `busy`
- core_out_valid  in  1  from core `out_valid`
- core_cv_next  in  160  from core `cv_next`
- digest_valid  out  1  final digest available
- digest_ready  in  1  consumer accepts digest
- digest  out  160  final hash value
- blk_count  out  CNT_W  blocks processed in the current or last message

Behaviour:
- Reset values (async on rstn low): state=IDLE, blk_ready=0, core_start=0, core_use_prev_cv=0, core_data=0, digest_valid=0, digest=0, blk_count=0, first-flag=1. core_cv is always SHA1_IV.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, OUT.
- IDLE:
  - blk_ready=1.
  - On blk_valid&&blk_ready, register blk_data into core_data and latch blk_last.
  - core_use_prev_cv = !first-flag.
  - Go to ISSUE.
- ISSUE:
  - core_start=1 for START_HOLD cycles. core_data and core_use_prev_cv remain stable.
  - Then go to WAIT_BUSY.
- WAIT_BUSY: wait for core_busy=1, then go to WAIT_DONE.
- WAIT_DONE:
  - On core_out_valid=1, or a core_busy falling edge, whichever comes first: blk_count += 1, saturating at all-ones.
  - If last: digest <= core_cv_next, digest_valid=1, go to OUT.
  - Otherwise: clear first-flag and go to IDLE.
- OUT:
  - blk_ready=0. digest_valid and digest held stable until digest_ready=1.
  - On accept: digest_valid=0, first-flag=1, go to IDLE.
  - blk_count clears on the next accepted first block, not on accept.
- blk_ready is 0 in every state except IDLE. blk_valid while not ready is ignored; the block is held upstream.
- Latency per block = 1 (accept) + START_HOLD + core latency + 1 (capture). Digest is valid the cycle after the last core_out_valid.
- Simultaneous core_out_valid and core_busy rise in WAIT_BUSY: treat as done and go directly to the WAIT_DONE action.
- Reset mid-message: all state discarded; the next block is treated as a first block with the IV.
- digest_ready high while digest_valid=0 has no effect.

Optional Feature:
- Macro: SHA1_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output `cyc_count` [31:0].
  - Counts clk cycles from acceptance of a first block to digest_valid rising, saturating.
  - Frozen while in OUT; cleared on the next first-block accept.
  - Reset value 0.
- Undefined: port absent, no counter logic.

Decomposition:
- Package sha1_pkg:
  - SHA1_IV = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0
  - BLK_W=512, CV_W=160
  - typedef of the FSM state enum
- No sub-module; a single flat FSM plus registers.

Test Plan:
- Single-block "abc" block ({"abc",8'h80,416'd0,64'd24}) with blk_last=1 → one core_start pulse with use_prev_cv=0; digest a9993e364706816aba3e25717850c26c9cd0d89d; blk_count=1.
- Two-block 448-bit "abcdbcdecdef…nopq" message → second issue has use_prev_cv=1; digest 84983e441c3bd26ebaae4aa1f95129e5e54670f1; blk_count=2.
- Hold digest_ready=0 for 10 cycles after digest_valid → digest stable, blk_ready=0 throughout; accept → digest_valid drops next cycle.
- Keep blk_valid high with a second message during the first → exactly one block accepted per IDLE visit; no core_start while core_busy=1.
- Assert rstn=0 during WAIT_DONE of block 1 of 2, then send "abc" → outputs reset immediately; result a9993e36…, use_prev_cv=0.
- With SHA1_SEQ_PERF_CNT_EN defined → cyc_count equals the measured accept-to-digest_valid cycles for the two-block test.
